mux_tree_pipe: RTL and testbench



---
 rtl/mux_tree_pipe.sv | 131 +++++++++++++
 tb/tb_mux_tree_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W : 1 multiplexer tree for the arbiter-PUF response path.
// The tree is built from 4:1 levels (the last level is 2:1 when SEL_W is odd),
// with one register stage per level and valid/ready flow control. A built-in
// scan sequencer sweeps inputs 0..N-1 so a whole response word can be read
// out without sequencing the select externally.
module mux_tree_pipe #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [(2**SEL_W)*DATA_W-1:0]    I,
  input  logic [SEL_W-1:0]                S,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic                            SCAN_START,
  output logic                            SCAN_BUSY,
  output logic [DATA_W-1:0]               O,
  output logic [SEL_W-1:0]                O_SEL,
  output logic                            O_VALID,
  input  logic                            O_READY
);

  localparam int N      = 2**SEL_W;
  localparam int LEVELS = (SEL_W + 1) / 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // Reject unsupported geometries at elaboration time.
  if (SEL_W < 1 || SEL_W > 8 || DATA_W < 1) begin : g_bad_params
    $error("mux_tree_pipe: SEL_W must be 1..8 and DATA_W must be >= 1");
  end

  logic [0:0]       state;
  logic [SEL_W-1:0] cnt;
  logic             en;
  logic             accept;
  logic             issue;
  logic [SEL_W-1:0] issue_sel;

  // The whole pipeline moves together: it advances whenever the output
  // register is empty or being drained, so no item is ever dropped or repeated.
  assign en        = !O_VALID || O_READY;
  assign IN_READY  = en && (state == IDLE) && !SCAN_START;
  assign accept    = IN_VALID && IN_READY;
  assign issue     = accept || ((state == SCAN) && en);
  assign issue_sel = (state == SCAN) ? cnt : S;
  assign SCAN_BUSY = (state == SCAN);

  // Scan sequencer: issues selects 0..N-1 on every enabled cycle, then idles.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (SCAN_START) begin
        state <= SCAN;
        cnt   <= '0;
      end
    end else if (en) begin
      if (cnt == SEL_W'(N - 1)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int IN_W  = SEL_W - 2*j;              // select bits still unresolved
    localparam int RB    = (IN_W >= 2) ? 2 : 1;      // bits resolved at this level
    localparam int IN_N  = 2**IN_W;
    localparam int OUT_N = 2**(IN_W - RB);

    logic [IN_N*DATA_W-1:0]  din;
    logic [SEL_W-1:0]        sel_in;
    logic                    vld_in;
    logic [OUT_N*DATA_W-1:0] dout_c;
    logic [OUT_N*DATA_W-1:0] dout_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    vld_q;

    if (j == 0) begin : g_head
      // I is only looked at here, in the cycle the item enters the tree.
      assign din    = I;
      assign sel_in = issue_sel;
      assign vld_in = issue;
    end else begin : g_link
      assign din    = g_lvl[j-1].dout_q;
      assign sel_in = g_lvl[j-1].sel_q;
      assign vld_in = g_lvl[j-1].vld_q;
    end

    // One 2**RB:1 mux per output group, steered by this level's select bits.
    // NOTE: the default assignment first keeps this block purely combinational.
    always_comb begin
      dout_c = '0;
      for (int k = 0; k < OUT_N; k++) begin
        dout_c[k*DATA_W +: DATA_W] =
          din[(k*(2**RB) + int'(sel_in[2*j +: RB]))*DATA_W +: DATA_W];
      end
    end

    // Stage register: valid follows the pipeline; payload only loads with a
    // real item, so O/O_SEL keep the last delivered value across bubbles.
    // NOTE: the payload is reset too, because O and O_SEL must read zero
    // straight after reset rather than whatever the flops powered up with.
    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_q  <= 1'b0;
        sel_q  <= '0;
        dout_q <= '0;
      end else if (en) begin
        vld_q <= vld_in;
        if (vld_in) begin
          sel_q  <= sel_in;
          dout_q <= dout_c;
        end
      end
    end
  end

  assign O       = g_lvl[LEVELS-1].dout_q;
  assign O_SEL   = g_lvl[LEVELS-1].sel_q;
  assign O_VALID = g_lvl[LEVELS-1].vld_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: single requests, back-to-back streaming,
// scan sweeps with backpressure and conflicts, mid-scan reset, odd SEL_W.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SEL_W=4, DATA_W=1
  logic [15:0] i4;
  logic [3:0]  s4, os4;
  logic        v4, ir4, ss4, sb4, o4, ov4, rd4;
  // SEL_W=4, DATA_W=8
  logic [127:0] i8;
  logic [3:0]   s8, os8;
  logic [7:0]   o8;
  logic         v8, ir8, ss8, sb8, ov8, rd8;
  // SEL_W=3, DATA_W=1
  logic [7:0] i3;
  logic [2:0] s3, os3;
  logic       v3, ir3, ss3, sb3, o3, ov3, rd3;

  mux_tree_pipe #(.SEL_W(4), .DATA_W(1)) u4 (
    .CLK(clk), .RST(rst), .I(i4), .S(s4), .IN_VALID(v4), .IN_READY(ir4),
    .SCAN_START(ss4), .SCAN_BUSY(sb4), .O(o4), .O_SEL(os4), .O_VALID(ov4),
    .O_READY(rd4));

  mux_tree_pipe #(.SEL_W(4), .DATA_W(8)) u8 (
    .CLK(clk), .RST(rst), .I(i8), .S(s8), .IN_VALID(v8), .IN_READY(ir8),
    .SCAN_START(ss8), .SCAN_BUSY(sb8), .O(o8), .O_SEL(os8), .O_VALID(ov8),
    .O_READY(rd8));

  mux_tree_pipe #(.SEL_W(3), .DATA_W(1)) u3 (
    .CLK(clk), .RST(rst), .I(i3), .S(s3), .IN_VALID(v3), .IN_READY(ir3),
    .SCAN_START(ss3), .SCAN_BUSY(sb3), .O(o3), .O_SEL(os3), .O_VALID(ov3),
    .O_READY(rd3));

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v4 = 0; v8 = 0; v3 = 0; ss4 = 0; ss8 = 0; ss3 = 0;
    rd4 = 1; rd8 = 1; rd3 = 1; s4 = 0; s8 = 0; s3 = 0;
    i4 = '0; i8 = '0; i3 = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_ov4: got %b want 0", ov4); end n_checks++;
    if (sb4 !== 1'b0) begin n_fail++; $display("FAIL reset_sb4: got %b want 0", sb4); end n_checks++;
    if (o4 !== 1'b0) begin n_fail++; $display("FAIL reset_o4: got %b want 0", o4); end n_checks++;
    if (os4 !== 4'd0) begin n_fail++; $display("FAIL reset_os4: got %0d want 0", os4); end n_checks++;
    if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_ir4: got %b want 1", ir4); end n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_ov8: got %b want 0", ov8); end n_checks++;
    if (o8 !== 8'h00) begin n_fail++; $display("FAIL reset_o8: got %h want 00", o8); end n_checks++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_ir8: got %b want 1", ir8); end n_checks++;
    if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_ov3: got %b want 0", ov3); end n_checks++;
    if (sb3 !== 1'b0) begin n_fail++; $display("FAIL reset_sb3: got %b want 0", sb3); end n_checks++;
    if (ir3 !== 1'b1) begin n_fail++; $display("FAIL reset_ir3: got %b want 1", ir3); end n_checks++;
  endtask

  task automatic test_single();
    int   sels [4] = '{0, 1, 2, 15};
    logic want [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    i4 = 16'hA5C3;
    rd4 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      s4 = 4'(sels[n]);
      v4 = 1'b1;
      #1;
      if (ir4 !== 1'b1) begin n_fail++; $display("FAIL single_ready s=%0d: got %b want 1", sels[n], ir4); end n_checks++;
      step();
      v4 = 1'b0;
      if (ov4 !== 1'b0) begin n_fail++; $display("FAIL single_early s=%0d: got valid %b want 0", sels[n], ov4); end n_checks++;
      step();
      if (ov4 !== 1'b1) begin n_fail++; $display("FAIL single_valid s=%0d: got %b want 1", sels[n], ov4); end n_checks++;
      if (o4 !== want[n]) begin n_fail++; $display("FAIL single_data s=%0d: got %b want %b", sels[n], o4, want[n]); end n_checks++;
      if (os4 !== 4'(sels[n])) begin n_fail++; $display("FAIL single_sel s=%0d: got %0d want %0d", sels[n], os4, sels[n]); end n_checks++;
      step();
      if (ov4 !== 1'b0) begin n_fail++; $display("FAIL single_drop s=%0d: got valid %b want 0", sels[n], ov4); end n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic want [16] = '{1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0};
    i4 = 16'h0F0F;
    rd4 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        s4 = 4'(c);
        v4 = 1'b1;
      end else begin
        v4 = 1'b0;
      end
      step();
      if (c >= 1 && c <= 16) begin
        if (ov4 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b want 1", c, ov4); end n_checks++;
        if (o4 !== want[c-1]) begin n_fail++; $display("FAIL b2b_data c=%0d: got %b want %b", c, o4, want[c-1]); end n_checks++;
        if (os4 !== 4'(c-1)) begin n_fail++; $display("FAIL b2b_sel c=%0d: got %0d want %0d", c, os4, c-1); end n_checks++;
      end else begin
        if (ov4 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c=%0d: got %b want 0", c, ov4); end n_checks++;
      end
    end
    v4 = 1'b0;
  endtask

  // Drives one scan on the 8-bit instance and checks order, holds and busy time.
  task automatic run_scan(input string tag, input bit with_req, input bit restart,
                          input bit stall, input int exp_busy);
    int idx = 0;
    int busy = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    for (int k = 0; k < 16; k++) i8[k*8 +: 8] = 8'(16 + k);
    rd8 = 1'b1;
    ss8 = 1'b1;
    if (with_req) begin
      v8 = 1'b1;
      s8 = 4'd3;
      #1;
      if (ir8 !== 1'b0) begin n_fail++; $display("FAIL %s_conflict_ready: got %b want 0", tag, ir8); end n_checks++;
    end
    while (idx < 16 && cyc < 100) begin
      step();
      cyc++;
      if (sb8) begin
        busy++;
        if (ir8 !== 1'b0) begin n_fail++; $display("FAIL %s_busy_ready cyc=%0d: got %b want 0", tag, cyc, ir8); end n_checks++;
      end
      if (ov8) begin
        if (stall && !stalled && os8 == 4'd6) begin
          stalled = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          rd8 = 1'b0;
          stall_left--;
          if (o8 !== 8'h16 || os8 !== 4'd6) begin n_fail++; $display("FAIL %s_hold: got %h/%0d want 16/6", tag, o8, os8); end n_checks++;
        end else begin
          rd8 = 1'b1;
          if (o8 !== 8'(16 + idx)) begin n_fail++; $display("FAIL %s_data item %0d: got %h want %h", tag, idx, o8, 8'(16 + idx)); end n_checks++;
          if (os8 !== 4'(idx)) begin n_fail++; $display("FAIL %s_sel item %0d: got %0d want %0d", tag, idx, os8, idx); end n_checks++;
          idx++;
        end
      end else begin
        rd8 = 1'b1;
      end
      ss8 = restart && (cyc == 5);
      v8 = 1'b0;
    end
    if (idx != 16) begin n_fail++; $display("FAIL %s_count: got %0d items want 16", tag, idx); end n_checks++;
    rd8 = 1'b1;
    ss8 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (sb8) busy++;
      if (ov8 !== 1'b0) begin n_fail++; $display("FAIL %s_extra t=%0d: got valid %b want 0", tag, t, ov8); end n_checks++;
    end
    if (busy != exp_busy) begin n_fail++; $display("FAIL %s_busy_len: got %0d want %0d", tag, busy, exp_busy); end n_checks++;
  endtask

  task automatic test_scan();
    run_scan("scan", 1'b0, 1'b0, 1'b0, 16);
  endtask

  task automatic test_backpressure();
    run_scan("bp", 1'b0, 1'b0, 1'b1, 21);
  endtask

  task automatic test_conflicts();
    run_scan("req_vs_scan", 1'b1, 1'b0, 1'b0, 16);
    run_scan("restart", 1'b0, 1'b1, 1'b0, 16);
  endtask

  task automatic test_reset_mid_scan();
    int acc = 0;
    int cyc = 0;
    for (int k = 0; k < 16; k++) i8[k*8 +: 8] = 8'(16 + k);
    rd8 = 1'b1;
    ss8 = 1'b1;
    while (acc < 7 && cyc < 50) begin
      step();
      cyc++;
      ss8 = 1'b0;
      if (ov8) acc++;
    end
    if (acc != 7) begin n_fail++; $display("FAIL rst_scan_progress: got %0d items want 7", acc); end n_checks++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL rst_scan_ov: got %b want 0", ov8); end n_checks++;
    if (sb8 !== 1'b0) begin n_fail++; $display("FAIL rst_scan_busy: got %b want 0", sb8); end n_checks++;
    if (o8 !== 8'h00) begin n_fail++; $display("FAIL rst_scan_o: got %h want 00", o8); end n_checks++;
    if (os8 !== 4'd0) begin n_fail++; $display("FAIL rst_scan_osel: got %0d want 0", os8); end n_checks++;
    for (int t = 0; t < 5; t++) begin
      step();
      if (ov8 !== 1'b0 || sb8 !== 1'b0) begin n_fail++; $display("FAIL rst_scan_stale t=%0d: got valid %b busy %b want 0 0", t, ov8, sb8); end n_checks++;
    end
    s8 = 4'd3;
    v8 = 1'b1;
    #1;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL rst_scan_ready: got %b want 1", ir8); end n_checks++;
    step();
    v8 = 1'b0;
    step();
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL rst_scan_req_valid: got %b want 1", ov8); end n_checks++;
    if (o8 !== 8'h13) begin n_fail++; $display("FAIL rst_scan_req_data: got %h want 13", o8); end n_checks++;
    if (os8 !== 4'd3) begin n_fail++; $display("FAIL rst_scan_req_sel: got %0d want 3", os8); end n_checks++;
    step();
  endtask

  task automatic test_odd_sel();
    logic want [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    i3 = 8'b1001_0110;
    rd3 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      s3 = 3'(s);
      v3 = 1'b1;
      step();
      v3 = 1'b0;
      if (ov3 !== 1'b0) begin n_fail++; $display("FAIL odd_early s=%0d: got valid %b want 0", s, ov3); end n_checks++;
      step();
      if (ov3 !== 1'b1) begin n_fail++; $display("FAIL odd_valid s=%0d: got %b want 1", s, ov3); end n_checks++;
      if (o3 !== want[s]) begin n_fail++; $display("FAIL odd_data s=%0d: got %b want %b", s, o3, want[s]); end n_checks++;
      if (os3 !== 3'(s)) begin n_fail++; $display("FAIL odd_sel s=%0d: got %0d want %0d", s, os3, s); end n_checks++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_scan();
    test_backpressure();
    test_conflicts();
    test_reset_mid_scan();
    test_odd_sel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
